// File: rtl/i2s_rate_sequencer_if.sv
// -----------------------------------------------------------------------------
// i2s_rate_sequencer_if
//
// APB bus between the rate sequencer (master) and the I2S clock-control
// register block (slave). The bus has no clock of its own. It runs on the clk
// that the sequencer receives.
//
// Signals:
//   paddr   [4:0]  register address (0x00 divisor/clk-select, 0x04 LRCLK divisor)
//   psel           transfer select
//   penable        access phase of a transfer
//   pwrite         1 = write, 0 = read
//   pwdata  [31:0] write data
//   prdata  [31:0] read data from the slave
//   pready         slave ready; extends the access phase while low
// -----------------------------------------------------------------------------
interface i2s_rate_sequencer_if;
   logic [4:0]  paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;

   modport master (
      output paddr, psel, penable, pwrite, pwdata,
      input  prdata, pready
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata,
      output prdata, pready
   );
endinterface

// File: rtl/i2s_rate_sequencer.sv
// -----------------------------------------------------------------------------
// i2s_rate_sequencer
//
// Performs a sample-rate change on the I2S clock-control block. The block is
// the only master on that block's APB port. The sequence is:
//   1. Mute the audio path. Wait for mute_ack, or continue after MUTE_TIMEOUT
//      cycles without it.
//   2. Write the divisor/clock-select register (0x00).
//   3. Write the LRCLK divisor register (0x04).
//   4. Optionally read both registers back and compare them (see below).
//   5. Wait SETTLE_CYCLES cycles for the dividers to settle.
//   6. Unmute the audio path and pulse done.
//
// Optional feature macro: I2S_RATESEQ_READBACK_EN
//   defined   : both registers are read back after the writes. A mismatch sets
//               the sticky err flag. The sequence takes 4 extra cycles.
//   undefined : the sequence goes from the second write straight to the settle
//               wait. err is constant 0 and prdata is ignored.
//
// Parameters:
//   SETTLE_CYCLES  cycles spent in SETTLE (>= 1)
//   MUTE_TIMEOUT   maximum cycles spent in MUTE while waiting for mute_ack (>= 1)
//   AUTO_BOOT      1: after reset, run one sequence with rate 0 and master mode
//
// Ports:
//   clk          clock (also the clock of the APB port)
//   reset_n      synchronous reset, active low
//   rate_req     one-cycle request strobe; ignored while busy
//   rate_sel     rate index (0 48k, 1 44.1k, 2 96k, 3 88.2k), taken with rate_req
//   master_mode  value for register bit 0, taken with rate_req
//   busy         high from request acceptance until the DONE cycle has ended
//   done         one-cycle pulse at the end of the sequence
//   err          sticky readback mismatch; cleared by the next accepted request
//   cur_rate     rate index of the last completed sequence
//   mute_req     mute request to the audio path
//   mute_ack     audio path reports that it is muted
//   apb          APB master port (i2s_rate_sequencer_if.master)
// -----------------------------------------------------------------------------
module i2s_rate_sequencer #(
   parameter int SETTLE_CYCLES = 4096,
   parameter int MUTE_TIMEOUT  = 1024,
   parameter int AUTO_BOOT     = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rate_req,
   input  logic [1:0] rate_sel,
   input  logic       master_mode,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] cur_rate,
   output logic       mute_req,
   input  logic       mute_ack,
   i2s_rate_sequencer_if.master apb
);

   // Counter widths. Each width is at least 1 so that a parameter value of 1
   // still gives a legal vector.
   localparam int MW = (MUTE_TIMEOUT  > 1) ? $clog2(MUTE_TIMEOUT)  : 1;
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [MW-1:0] MUTE_LAST   = MW'(MUTE_TIMEOUT - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   localparam logic [4:0] ADDR_DIV = 5'h00;
   localparam logic [4:0] ADDR_LR  = 5'h04;

   typedef enum logic [3:0] {
      IDLE,
      MUTE,
      W1_SETUP,
      W1_ACC,
      W2_SETUP,
      W2_ACC,
      R1_SETUP,
      R1_ACC,
      R2_SETUP,
      R2_ACC,
      SETTLE,
      DONE
   } state_t;

   state_t          state;
   logic            boot_pend;
   logic [1:0]      rate_q;
   logic            master_q;
   logic [MW-1:0]   mute_cnt;
   logic [SW-1:0]   settle_cnt;

   // Register 0x00: {mclk_div, bclk_div, 14'b0, clk_sel, master}.
   // The 44.1k family (indices 1 and 3) uses the second reference clock.
   function automatic logic [31:0] div_word(input logic [1:0] r, input logic m);
      logic [7:0] bclk;
      logic       clk_sel;
      case (r)
         2'd0:    begin bclk = 8'h03; clk_sel = 1'b0; end
         2'd1:    begin bclk = 8'h05; clk_sel = 1'b1; end
         2'd2:    begin bclk = 8'h01; clk_sel = 1'b0; end
         default: begin bclk = 8'h02; clk_sel = 1'b1; end
      endcase
      return {8'h00, bclk, 14'b0, clk_sel, m};
   endfunction

   // Register 0x04: {16'b0, lr1, lr2}. Both LRCLK dividers use the same value.
   function automatic logic [31:0] lr_word(input logic [1:0] r);
      logic [7:0] lr;
      case (r)
         2'd0:    lr = 8'h0F;
         2'd1:    lr = 8'h17;
         2'd2:    lr = 8'h07;
         default: lr = 8'h0B;
      endcase
      return {16'h0000, lr, lr};
   endfunction

`ifndef I2S_RATESEQ_READBACK_EN
   // Without readback the read data bus has no consumer.
   logic unused_prdata;
   assign unused_prdata = ^apb.prdata;
   assign err = 1'b0;
`endif

   // NOTE: all state and registered outputs are updated with non-blocking
   // assignments inside one clocked block. The reset is synchronous, so it
   // is just the highest-priority branch of that block.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         boot_pend   <= (AUTO_BOOT != 0);
         rate_q      <= 2'd0;
         master_q    <= 1'b0;
         mute_cnt    <= '0;
         settle_cnt  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
`ifdef I2S_RATESEQ_READBACK_EN
         err         <= 1'b0;
`endif
         cur_rate    <= 2'd0;
         mute_req    <= 1'b0;
         apb.psel    <= 1'b0;
         apb.penable <= 1'b0;
         apb.pwrite  <= 1'b0;
         apb.paddr   <= 5'h00;
         apb.pwdata  <= 32'h0;
      end else begin
         done <= 1'b0;

         case (state)
            IDLE: begin
               // The pending boot sequence has priority over any request
               // that arrives in the same cycle.
               if (boot_pend || rate_req) begin
                  boot_pend <= 1'b0;
                  rate_q    <= boot_pend ? 2'd0 : rate_sel;
                  master_q  <= boot_pend ? 1'b1 : master_mode;
                  busy      <= 1'b1;
                  mute_req  <= 1'b1;
`ifdef I2S_RATESEQ_READBACK_EN
                  err       <= 1'b0;
`endif
                  mute_cnt  <= '0;
                  state     <= MUTE;
               end
            end

            MUTE: begin
               // mute_cnt counts the MUTE cycles already spent, so the
               // timeout exit happens on cycle MUTE_TIMEOUT.
               if (mute_ack || mute_cnt == MUTE_LAST) begin
                  apb.psel    <= 1'b1;
                  apb.penable <= 1'b0;
                  apb.pwrite  <= 1'b1;
                  apb.paddr   <= ADDR_DIV;
                  apb.pwdata  <= div_word(rate_q, master_q);
                  state       <= W1_SETUP;
               end else begin
                  mute_cnt <= mute_cnt + 1'b1;
               end
            end

            W1_SETUP: begin
               apb.penable <= 1'b1;
               state       <= W1_ACC;
            end

            W1_ACC: begin
               // psel stays high, so the second setup phase follows this
               // access phase directly with no idle cycle.
               if (apb.pready) begin
                  apb.penable <= 1'b0;
                  apb.paddr   <= ADDR_LR;
                  apb.pwdata  <= lr_word(rate_q);
                  state       <= W2_SETUP;
               end
            end

            W2_SETUP: begin
               apb.penable <= 1'b1;
               state       <= W2_ACC;
            end

            W2_ACC: begin
               if (apb.pready) begin
                  apb.penable <= 1'b0;
`ifdef I2S_RATESEQ_READBACK_EN
                  apb.pwrite  <= 1'b0;
                  apb.paddr   <= ADDR_DIV;
                  state       <= R1_SETUP;
`else
                  apb.psel    <= 1'b0;
                  apb.pwrite  <= 1'b0;
                  settle_cnt  <= '0;
                  state       <= SETTLE;
`endif
               end
            end

`ifdef I2S_RATESEQ_READBACK_EN
            R1_SETUP: begin
               apb.penable <= 1'b1;
               state       <= R1_ACC;
            end

            R1_ACC: begin
               if (apb.pready) begin
                  if (apb.prdata != div_word(rate_q, master_q)) err <= 1'b1;
                  apb.penable <= 1'b0;
                  apb.paddr   <= ADDR_LR;
                  state       <= R2_SETUP;
               end
            end

            R2_SETUP: begin
               apb.penable <= 1'b1;
               state       <= R2_ACC;
            end

            R2_ACC: begin
               if (apb.pready) begin
                  if (apb.prdata != lr_word(rate_q)) err <= 1'b1;
                  apb.psel    <= 1'b0;
                  apb.penable <= 1'b0;
                  settle_cnt  <= '0;
                  state       <= SETTLE;
               end
            end
`endif

            SETTLE: begin
               // The audio path stays muted until the dividers have settled.
               if (settle_cnt == SETTLE_LAST) begin
                  mute_req <= 1'b0;
                  done     <= 1'b1;
                  cur_rate <= rate_q;
                  state    <= DONE;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end

            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2s_rate_sequencer.sv
// -----------------------------------------------------------------------------
// tb_i2s_rate_sequencer
//
// Directed testbench for i2s_rate_sequencer. It uses small SETTLE and MUTE
// parameters. A simple APB register slave is built in, and its pready and
// read data can be forced. Inputs are driven and outputs are sampled on the
// falling clock edge. Tick k after an acceptance edge shows cycle N+k.
// -----------------------------------------------------------------------------
module tb_i2s_rate_sequencer;
   localparam int S = 8;
   localparam int T = 5;
`ifdef I2S_RATESEQ_READBACK_EN
   localparam int RB = 4;
`else
   localparam int RB = 0;
`endif
   // Number of ticks from acceptance to the done cycle with immediate mute_ack:
   // 1 (MUTE) + 4 (two writes) + RB + S + 1 (DONE).
   localparam int BASE_LAT = 6 + S + RB;
   localparam int MAX_WAIT = 200;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rate_req = 1'b0;
   logic [1:0] rate_sel = 2'd0;
   logic       master_mode = 1'b0;
   logic       mute_ack = 1'b1;
   logic       busy, done, err, mute_req;
   logic [1:0] cur_rate;

   logic        pready_low = 1'b0;
   logic        corrupt = 1'b0;
   logic [31:0] mem0 = 32'h0;
   logic [31:0] mem1 = 32'h0;
   logic [36:0] wlog[$];

   int n_cmp = 0;
   int n_err = 0;

   i2s_rate_sequencer_if apb ();

   i2s_rate_sequencer #(
      .SETTLE_CYCLES(S),
      .MUTE_TIMEOUT (T),
      .AUTO_BOOT    (1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rate_req   (rate_req),
      .rate_sel   (rate_sel),
      .master_mode(master_mode),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .cur_rate   (cur_rate),
      .mute_req   (mute_req),
      .mute_ack   (mute_ack),
      .apb        (apb.master)
   );

   always #5 clk = ~clk;

   // Register slave: two registers. Reads of 0x00 can be corrupted on purpose.
   assign apb.pready = ~pready_low;
   assign apb.prdata = (apb.paddr == 5'h00) ? (corrupt ? (mem0 & 32'hFFFF_FFFE) : mem0) : mem1;

   always @(posedge clk) begin
      if (apb.psel && apb.penable && apb.pready && apb.pwrite) begin
         wlog.push_back({apb.paddr, apb.pwdata});
         if (apb.paddr == 5'h00) mem0 <= apb.pwdata;
         else                    mem1 <= apb.pwdata;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // Drives rate_req for one cycle. The task returns on tick 1 after the
   // acceptance edge.
   task automatic pulse_req(input logic [1:0] r, input logic m);
      rate_sel    = r;
      master_mode = m;
      rate_req    = 1'b1;
      tick();
      rate_req    = 1'b0;
   endtask

   // Ticks until done is seen, up to max_cyc ticks in total. cyc holds the
   // tick count since acceptance.
   task automatic wait_done(input int max_cyc, inout int cyc, output bit ok);
      while (done !== 1'b1 && cyc < max_cyc) begin
         tick();
         cyc++;
      end
      ok = (done === 1'b1);
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      mute_ack = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if ({busy, done, err, cur_rate, mute_req, apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata} !== '0) begin
         n_err++;
         $display("FAIL reset_values: got busy=%b done=%b err=%b cur_rate=%0d mute_req=%b psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h, want all 0",
                  busy, done, err, cur_rate, mute_req, apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata);
      end
   endtask

   task automatic test_boot();
      int cyc;
      bit ok;
      wlog.delete();
      reset_n = 1'b1;
      tick();
      n_cmp++;
      if ({busy, mute_req} !== 2'b11) begin
         n_err++; $display("FAIL boot_start: got busy=%b mute_req=%b want 1 1", busy, mute_req);
      end
      tick();
      n_cmp++;
      if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata} !== {1'b1, 1'b0, 1'b1, 5'h00, 32'h0003_0001}) begin
         n_err++; $display("FAIL boot_w1_setup: got psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h want 1 0 1 00 00030001",
                           apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata);
      end
      tick();
      n_cmp++;
      if ({apb.psel, apb.penable} !== 2'b11) begin
         n_err++; $display("FAIL boot_w1_acc: got psel=%b penable=%b want 1 1", apb.psel, apb.penable);
      end
      cyc = 3;
      wait_done(MAX_WAIT, cyc, ok);
      n_cmp++;
      if (!ok || cyc != BASE_LAT) begin
         n_err++; $display("FAIL boot_latency: got done=%b after %0d cycles want done after %0d", done, cyc, BASE_LAT);
      end
      n_cmp++;
      if ({cur_rate, mute_req, busy} !== {2'd0, 1'b0, 1'b1}) begin
         n_err++; $display("FAIL boot_done_state: got cur_rate=%0d mute_req=%b busy=%b want 0 0 1", cur_rate, mute_req, busy);
      end
      n_cmp++;
      if (wlog.size() != 2 || wlog[0] !== {5'h00, 32'h0003_0001} || wlog[1] !== {5'h04, 32'h0000_0F0F}) begin
         n_err++; $display("FAIL boot_writes: got n=%0d w0=%h w1=%h want 2 0000030001 0400000f0f", wlog.size(), wlog[0], wlog[1]);
      end
      tick();
      n_cmp++;
      if ({done, busy} !== 2'b00) begin
         n_err++; $display("FAIL boot_after_done: got done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_rate1();
      int cyc;
      bit ok;
      bit mute_ok;
      wlog.delete();
      pulse_req(2'd1, 1'b1);
      cyc = 1;
      n_cmp++;
      if ({busy, mute_req} !== 2'b11) begin
         n_err++; $display("FAIL rate1_accept: got busy=%b mute_req=%b want 1 1", busy, mute_req);
      end
      mute_ok = 1'b1;
      // Once the first write has started, mute_ack is dropped. The sequence
      // must not react to it.
      while (done !== 1'b1 && cyc < MAX_WAIT) begin
         if (mute_req !== 1'b1) mute_ok = 1'b0;
         if (apb.psel === 1'b1) mute_ack = 1'b0;
         tick();
         cyc++;
      end
      n_cmp++;
      if (done !== 1'b1 || cyc != BASE_LAT) begin
         n_err++; $display("FAIL rate1_latency: got done=%b after %0d cycles want done after %0d", done, cyc, BASE_LAT);
      end
      n_cmp++;
      if (!mute_ok) begin
         n_err++; $display("FAIL rate1_mute_held: got mute_req low while busy, want high until DONE");
      end
      n_cmp++;
      if ({cur_rate, mute_req} !== {2'd1, 1'b0}) begin
         n_err++; $display("FAIL rate1_done_state: got cur_rate=%0d mute_req=%b want 1 0", cur_rate, mute_req);
      end
      n_cmp++;
      if (wlog.size() != 2 || wlog[0] !== {5'h00, 32'h0005_0003} || wlog[1] !== {5'h04, 32'h0000_1717}) begin
         n_err++; $display("FAIL rate1_writes: got n=%0d w0=%h w1=%h want 2 0000050003 0400001717", wlog.size(), wlog[0], wlog[1]);
      end
      mute_ack = 1'b1;
      tick();
   endtask

   task automatic test_mute_timeout();
      int cyc;
      int mcnt;
      bit ok;
      wlog.delete();
      mute_ack = 1'b0;
      pulse_req(2'd3, 1'b1);
      cyc  = 1;
      mcnt = 0;
      while (apb.psel !== 1'b1 && cyc < MAX_WAIT) begin
         mcnt++;
         tick();
         cyc++;
      end
      n_cmp++;
      if (mcnt != T) begin
         n_err++; $display("FAIL mute_timeout_len: got %0d MUTE cycles want %0d", mcnt, T);
      end
      mute_ack = 1'b1;
      wait_done(MAX_WAIT, cyc, ok);
      n_cmp++;
      if (!ok || cyc != BASE_LAT + T - 1) begin
         n_err++; $display("FAIL mute_timeout_latency: got done=%b after %0d cycles want done after %0d", done, cyc, BASE_LAT + T - 1);
      end
      n_cmp++;
      if (wlog.size() != 2 || wlog[0] !== {5'h00, 32'h0002_0003} || wlog[1] !== {5'h04, 32'h0000_0B0B} || cur_rate !== 2'd3) begin
         n_err++; $display("FAIL mute_timeout_writes: got n=%0d w0=%h w1=%h cur_rate=%0d want 2 0000020003 0400000b0b 3",
                           wlog.size(), wlog[0], wlog[1], cur_rate);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit ok;
      wlog.delete();
      pulse_req(2'd2, 1'b0);
      tick();                      // tick 2: W1_SETUP
      pready_low = 1'b1;
      tick();                      // tick 3: first W1_ACC cycle
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata} !== {1'b1, 1'b1, 1'b1, 5'h00, 32'h0001_0000}) begin
            n_err++; $display("FAIL stall_stable_%0d: got psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h want 1 1 1 00 00010000",
                              i, apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata);
         end
         // This request arrives while busy and must be dropped.
         if (i == 0) begin rate_sel = 2'd1; master_mode = 1'b1; rate_req = 1'b1; end
         if (i == 1) rate_req = 1'b0;
         if (i == 3) pready_low = 1'b0;
         tick();
      end
      cyc = 7;
      n_cmp++;
      if ({apb.psel, apb.penable, apb.paddr} !== {1'b1, 1'b0, 5'h04}) begin
         n_err++; $display("FAIL stall_w2_setup: got psel=%b penable=%b paddr=%h want 1 0 04", apb.psel, apb.penable, apb.paddr);
      end
      wait_done(MAX_WAIT, cyc, ok);
      n_cmp++;
      if (!ok || cyc != BASE_LAT + 3) begin
         n_err++; $display("FAIL stall_latency: got done=%b after %0d cycles want done after %0d", done, cyc, BASE_LAT + 3);
      end
      n_cmp++;
      if (wlog.size() != 2 || wlog[0] !== {5'h00, 32'h0001_0000} || wlog[1] !== {5'h04, 32'h0000_0707} || cur_rate !== 2'd2) begin
         n_err++; $display("FAIL stall_writes: got n=%0d w0=%h w1=%h cur_rate=%0d want 2 0000010000 0400000707 2",
                           wlog.size(), wlog[0], wlog[1], cur_rate);
      end
      repeat (3) tick();
      n_cmp++;
      if ({busy, mute_req, apb.psel} !== 3'b000) begin
         n_err++; $display("FAIL ignored_req: got busy=%b mute_req=%b psel=%b want 0 0 0", busy, mute_req, apb.psel);
      end
   endtask

`ifdef I2S_RATESEQ_READBACK_EN
   task automatic test_readback();
      int cyc;
      bit ok;
      corrupt = 1'b1;
      pulse_req(2'd2, 1'b1);
      cyc = 1;
      wait_done(MAX_WAIT, cyc, ok);
      n_cmp++;
      if (!ok || err !== 1'b1) begin
         n_err++; $display("FAIL readback_err: got done=%b err=%b want 1 1", done, err);
      end
      corrupt = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if ({err, busy} !== 2'b10) begin
         n_err++; $display("FAIL readback_sticky: got err=%b busy=%b want 1 0", err, busy);
      end
      pulse_req(2'd0, 1'b1);
      cyc = 1;
      n_cmp++;
      if (err !== 1'b0) begin
         n_err++; $display("FAIL readback_clear: got err=%b want 0", err);
      end
      wait_done(MAX_WAIT, cyc, ok);
      n_cmp++;
      if (!ok || err !== 1'b0 || cyc != BASE_LAT) begin
         n_err++; $display("FAIL readback_clean: got done=%b err=%b after %0d cycles want 1 0 after %0d", done, err, cyc, BASE_LAT);
      end
      tick();
   endtask
`endif

   task automatic test_reset_mid();
      int cyc;
      bit ok;
      pulse_req(2'd1, 1'b0);
      repeat (3) tick();           // tick 4: W2_SETUP
      n_cmp++;
      if ({apb.psel, apb.penable, apb.paddr} !== {1'b1, 1'b0, 5'h04}) begin
         n_err++; $display("FAIL midrst_at_w2: got psel=%b penable=%b paddr=%h want 1 0 04", apb.psel, apb.penable, apb.paddr);
      end
      reset_n = 1'b0;
      tick();
      n_cmp++;
      if ({busy, done, err, cur_rate, mute_req, apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata} !== '0) begin
         n_err++;
         $display("FAIL midrst_values: got busy=%b done=%b err=%b cur_rate=%0d mute_req=%b psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h, want all 0",
                  busy, done, err, cur_rate, mute_req, apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata);
      end
      tick();
      reset_n = 1'b1;
      tick();
      n_cmp++;
      if ({busy, mute_req} !== 2'b11) begin
         n_err++; $display("FAIL midrst_reboot: got busy=%b mute_req=%b want 1 1", busy, mute_req);
      end
      cyc = 1;
      wait_done(MAX_WAIT, cyc, ok);
      n_cmp++;
      if (!ok || cyc != BASE_LAT || cur_rate !== 2'd0) begin
         n_err++; $display("FAIL midrst_reboot_done: got done=%b after %0d cycles cur_rate=%0d want 1 after %0d rate 0",
                           done, cyc, cur_rate, BASE_LAT);
      end
      tick();
   endtask

   initial begin
      tick();
      test_reset();
      test_boot();
      test_rate1();
      test_mute_timeout();
      test_back_to_back();
`ifdef I2S_RATESEQ_READBACK_EN
      test_readback();
`endif
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
